// File: rtl/xg_mem_responder.sv
// XenonGecko memory responder: serves aligned four-word read/write bursts from a
// synchronous RAM port with a configurable read latency.
module xg_mem_responder #(
    parameter int unsigned RAM_LATENCY = 1,
    parameter int unsigned ADDR_W      = 16
) (
    input  logic              clk_sys,
    input  logic              rst_n,
    input  logic              mem_req,
    input  logic              mem_wren,
    input  logic [23:0]       mem_addr,
    input  logic [15:0]       to_mem,
    output logic              mem_ready,
    output logic [1:0]        mem_offset,
    output logic [15:0]       from_mem,
    output logic              busy,
    output logic              req_overrun,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wren,
    output logic [15:0]       ram_wdata,
    input  logic [15:0]       ram_rdata
);

    localparam int unsigned Tail = RAM_LATENCY - 1;

    if (RAM_LATENCY < 1 || RAM_LATENCY > 4) begin : g_bad_latency
        $error("RAM_LATENCY must be in 1..4");
    end

    typedef enum logic [1:0] {
        StIdle,
        StRdIssue,
        StRdDrain,
        StWrBurst
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-3:0] base_q, base_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              ready_q, ready_d;
    logic [1:0]        off_q, off_d;
    logic [15:0]       rdata_q, rdata_d;
    logic              overrun_q, overrun_d;
    logic              issue;
    logic              pv_q [RAM_LATENCY];
    logic [1:0]        po_q [RAM_LATENCY];
    logic              unused_addr;

    // Base is stored without its two zero LSBs, so base + i is a concatenation.
    assign unused_addr = ^mem_addr;

    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        cnt_d     = cnt_q;
        issue     = 1'b0;
        overrun_d = overrun_q | (mem_req & (state_q != StIdle));
        // Read beats emerge from the tail of the valid/offset pipe.
        ready_d   = pv_q[Tail];
        off_d     = pv_q[Tail] ? po_q[Tail] : off_q;
        rdata_d   = pv_q[Tail] ? ram_rdata : rdata_q;

        unique case (state_q)
            StIdle: begin
                if (mem_req) begin
                    base_d = mem_addr[ADDR_W-1:2];
                    cnt_d  = 2'd0;
                    if (mem_wren) begin
                        state_d = StWrBurst;
                        ready_d = 1'b1;
                        off_d   = 2'd0;
                    end else begin
                        state_d = StRdIssue;
                    end
                end
            end
            StRdIssue: begin
                issue = 1'b1;
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    state_d = StRdDrain;
                end
            end
            StRdDrain: begin
                if (ready_q && (off_q == 2'd3)) begin
                    state_d = StIdle;
                end
            end
            StWrBurst: begin
                if (off_q == 2'd3) begin
                    ready_d = 1'b0;
                    state_d = StIdle;
                end else begin
                    ready_d = 1'b1;
                    off_d   = off_q + 2'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            base_q    <= '0;
            cnt_q     <= 2'd0;
            ready_q   <= 1'b0;
            off_q     <= 2'd0;
            rdata_q   <= 16'h0000;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            cnt_q     <= cnt_d;
            ready_q   <= ready_d;
            off_q     <= off_d;
            rdata_q   <= rdata_d;
            overrun_q <= overrun_d;
        end
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RAM_LATENCY; i++) begin
                pv_q[i] <= 1'b0;
                po_q[i] <= 2'd0;
            end
        end else begin
            pv_q[0] <= issue;
            po_q[0] <= cnt_q;
            for (int i = 1; i < RAM_LATENCY; i++) begin
                pv_q[i] <= pv_q[i-1];
                po_q[i] <= po_q[i-1];
            end
        end
    end

    always_comb begin
        ram_addr = '0;
        if (state_q == StRdIssue) begin
            ram_addr = {base_q, cnt_q};
        end else if (state_q == StWrBurst) begin
            ram_addr = {base_q, off_q};
        end
    end

    assign ram_wren    = (state_q == StWrBurst) & ready_q;
    assign ram_wdata   = to_mem;
    assign mem_ready   = ready_q;
    assign mem_offset  = off_q;
    assign from_mem    = rdata_q;
    assign busy        = (state_q != StIdle);
    assign req_overrun = overrun_q;

endmodule

// File: tb/tb_xg_mem_responder.sv
// Scoreboard bench for xg_mem_responder: two instances (RAM latency 1 and 4) share
// stimulus; expected beats come from a word-addressed memory model.
module tb_xg_mem_responder;

    localparam int unsigned AW = 16;

    typedef struct {
        int          cyc;
        bit          wr;
        logic [1:0]  off;
        logic [15:0] addr;
        logic [15:0] data;
    } exp_t;

    logic        clk_sys = 1'b0;
    logic        rst_n;
    logic        mem_req;
    logic        mem_wren;
    logic [23:0] mem_addr;
    logic [15:0] to_mem;

    logic [1:0]  mem_ready;
    logic [1:0]  busy;
    logic [1:0]  req_overrun;
    logic [1:0]  ram_wren;
    logic [1:0]  mem_offset [2];
    logic [15:0] from_mem   [2];
    logic [15:0] ram_addr   [2];
    logic [15:0] ram_wdata  [2];
    logic [15:0] ram_rdata  [2];

    exp_t        sb [2][$];
    int          lo [2];
    int          hi [2];
    int          rd_t;
    logic [15:0] rd_base;
    logic [15:0] ref_mem [int];
    logic [15:0] wdata [4];
    int          cyc = 0;
    int          checks;
    int          errors;

    always #5 clk_sys = ~clk_sys;
    always @(posedge clk_sys) cyc <= cyc + 1;

    function automatic int lat_of(input int g);
        return (g == 0) ? 1 : 4;
    endfunction

    function automatic logic [15:0] init_val(input logic [15:0] a);
        if (a >= 16'h0100 && a <= 16'h0103) return 16'hA000 + (a - 16'h0100);
        return (a * 16'h9E37) ^ 16'h5A5A;
    endfunction

    function automatic logic [15:0] ref_rd(input logic [15:0] a);
        if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
        return init_val(a);
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int unsigned LAT = (g == 0) ? 1 : 4;

        logic [15:0] mem     [65536];
        bit          wr_flag [65536];
        logic [15:0] sh      [LAT];
        exp_t        e;
        bit          ok;

        xg_mem_responder #(
            .RAM_LATENCY(LAT),
            .ADDR_W     (AW)
        ) dut (
            .clk_sys    (clk_sys),
            .rst_n      (rst_n),
            .mem_req    (mem_req),
            .mem_wren   (mem_wren),
            .mem_addr   (mem_addr),
            .to_mem     (to_mem),
            .mem_ready  (mem_ready[g]),
            .mem_offset (mem_offset[g]),
            .from_mem   (from_mem[g]),
            .busy       (busy[g]),
            .req_overrun(req_overrun[g]),
            .ram_addr   (ram_addr[g]),
            .ram_wren   (ram_wren[g]),
            .ram_wdata  (ram_wdata[g]),
            .ram_rdata  (ram_rdata[g])
        );

        // Synchronous RAM with LAT cycles from address to data.
        always @(posedge clk_sys) begin
            sh[0] <= wr_flag[ram_addr[g]] ? mem[ram_addr[g]] : init_val(ram_addr[g]);
            for (int i = 1; i < LAT; i++) sh[i] <= sh[i-1];
            if (ram_wren[g]) begin
                mem[ram_addr[g]]     <= ram_wdata[g];
                wr_flag[ram_addr[g]] <= 1'b1;
            end
        end
        assign ram_rdata[g] = sh[LAT-1];

        always @(negedge clk_sys) begin
            if (rst_n) begin
                checks++;
                if (busy[g] !== (cyc >= lo[g] && cyc <= hi[g])) begin
                    errors++;
                    $display("FAIL busy[%0d] cyc=%0d got=%b want=%b", g, cyc, busy[g],
                             (cyc >= lo[g] && cyc <= hi[g]));
                end
                if (cyc > rd_t && cyc <= rd_t + 4) begin
                    checks++;
                    if (ram_addr[g] !== rd_base + 16'(cyc - rd_t - 1)) begin
                        errors++;
                        $display("FAIL rd_addr[%0d] cyc=%0d got=%h want=%h", g, cyc, ram_addr[g],
                                 rd_base + 16'(cyc - rd_t - 1));
                    end
                end
                if (mem_ready[g]) begin
                    checks++;
                    if (sb[g].size() == 0) begin
                        errors++;
                        $display("FAIL extra_beat[%0d] cyc=%0d got off=%0d want no beat", g, cyc,
                                 mem_offset[g]);
                    end else begin
                        e  = sb[g].pop_front();
                        ok = (cyc == e.cyc) && (mem_offset[g] == e.off);
                        if (e.wr) begin
                            ok = ok && ram_wren[g] && (ram_addr[g] == e.addr)
                                    && (ram_wdata[g] == e.data);
                        end else begin
                            ok = ok && !ram_wren[g] && (from_mem[g] == e.data);
                        end
                        if (!ok) begin
                            errors++;
                            $display({"FAIL beat[%0d] got cyc=%0d off=%0d rdata=%h wren=%b ",
                                      "addr=%h wdata=%h want cyc=%0d off=%0d wr=%b addr=%h ",
                                      "data=%h"}, g, cyc, mem_offset[g], from_mem[g], ram_wren[g],
                                     ram_addr[g], ram_wdata[g], e.cyc, e.off, e.wr, e.addr,
                                     e.data);
                        end
                    end
                end
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (busy != 2'b00 && n < 300) begin
            @(posedge clk_sys);
            #1;
            n++;
        end
        if (busy != 2'b00) begin
            checks++;
            errors++;
            $display("FAIL wait_idle got busy=%b want 00 within 300 cycles", busy);
        end
    endtask

    task automatic check_reset(input string name);
        for (int g = 0; g < 2; g++) begin
            checks++;
            if ({mem_ready[g], mem_offset[g], from_mem[g], busy[g], req_overrun[g], ram_wren[g],
                 ram_addr[g]} !== '0) begin
                errors++;
                $display({"FAIL %s[%0d] got ready=%b off=%0d rdata=%h busy=%b ovr=%b wren=%b ",
                          "addr=%h want all zero"}, name, g, mem_ready[g], mem_offset[g],
                         from_mem[g], busy[g], req_overrun[g], ram_wren[g], ram_addr[g]);
            end
        end
    endtask

    task automatic check_overrun(input logic want);
        for (int g = 0; g < 2; g++) begin
            checks++;
            if (req_overrun[g] !== want) begin
                errors++;
                $display("FAIL req_overrun[%0d] got=%b want=%b", g, req_overrun[g], want);
            end
        end
    endtask

    // Push expectations for beats 0..nbeats-1 of a burst accepted this cycle.
    task automatic expect_burst(input bit wr, input logic [23:0] addr, input int nbeats);
        logic [15:0] base;
        logic [15:0] a;
        exp_t        x;
        int          t;
        base = addr[15:0] & 16'hFFFC;
        t    = cyc;
        for (int g = 0; g < 2; g++) begin
            for (int k = 0; k < nbeats; k++) begin
                a      = base + 16'(k);
                x.cyc  = wr ? t + 1 + k : t + 2 + lat_of(g) + k;
                x.wr   = wr;
                x.off  = 2'(k);
                x.addr = a;
                x.data = wr ? wdata[k] : ref_rd(a);
                sb[g].push_back(x);
            end
            lo[g] = t + 1;
            hi[g] = wr ? t + nbeats : t + 5 + lat_of(g);
        end
        if (wr) begin
            for (int k = 0; k < nbeats; k++) ref_mem[int'(base + 16'(k))] = wdata[k];
        end else begin
            rd_t    = t;
            rd_base = base;
        end
    endtask

    // Returns #1 after the edge ending the acceptance cycle (reads) or the last beat (writes).
    task automatic burst(input bit wr, input logic [23:0] addr);
        wait_idle();
        expect_burst(wr, addr, 4);
        mem_req  = 1'b1;
        mem_wren = wr;
        mem_addr = addr;
        @(posedge clk_sys);
        #1;
        mem_req  = 1'b0;
        mem_wren = 1'($urandom);
        mem_addr = 24'($urandom);
        if (wr) begin
            for (int k = 0; k < 4; k++) begin
                to_mem = wdata[k];
                @(posedge clk_sys);
                #1;
            end
            to_mem = 16'($urandom);
        end
    endtask

    initial begin
        logic [23:0] addr;
        bit          wr;

        rst_n    = 1'b0;
        mem_req  = 1'b0;
        mem_wren = 1'b0;
        mem_addr = '0;
        to_mem   = '0;
        checks   = 0;
        errors   = 0;
        rd_t     = -100;
        rd_base  = '0;
        lo       = '{1, 1};
        hi       = '{0, 0};

        repeat (3) @(posedge clk_sys);
        #1;
        check_reset("reset_state");
        rst_n = 1'b1;
        @(posedge clk_sys);
        #1;
        check_reset("idle_after_reset");

        burst(1'b0, 24'h000100);
        for (int k = 0; k < 4; k++) wdata[k] = 16'h5500 + 16'(k);
        burst(1'b1, 24'h010204);
        burst(1'b0, 24'h000204);
        burst(1'b0, 24'h000107);
        burst(1'b0, 24'hFF0104);
        burst(1'b0, 24'h000104);
        check_overrun(1'b0);

        // Request arriving two cycles into a read is dropped.
        burst(1'b0, 24'h000200);
        @(posedge clk_sys);
        #1;
        mem_req = 1'b1;
        @(posedge clk_sys);
        #1;
        mem_req = 1'b0;
        wait_idle();
        check_overrun(1'b1);
        burst(1'b0, 24'h000300);
        wait_idle();
        check_overrun(1'b1);

        // Reset right after beat 1 of a write lands.
        for (int k = 0; k < 4; k++) wdata[k] = 16'hC3C0 + 16'(k);
        wait_idle();
        expect_burst(1'b1, 24'h000400, 2);
        mem_req  = 1'b1;
        mem_wren = 1'b1;
        mem_addr = 24'h000400;
        @(posedge clk_sys);
        #1;
        mem_req = 1'b0;
        to_mem  = wdata[0];
        @(posedge clk_sys);
        #1;
        to_mem = wdata[1];
        @(posedge clk_sys);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset("async_reset");
        lo = '{1, 1};
        hi = '{0, 0};
        repeat (3) @(posedge clk_sys);
        #1;
        rst_n = 1'b1;
        @(posedge clk_sys);
        #1;
        check_overrun(1'b0);
        burst(1'b0, 24'h000400);

        for (int n = 0; n < 40; n++) begin
            wr   = 1'($urandom);
            addr = 24'($urandom);
            if ($urandom_range(0, 1) == 1) addr[15:0] = addr[15:0] & 16'h003F;
            for (int k = 0; k < 4; k++) wdata[k] = 16'($urandom);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk_sys);
                #1;
            end
            burst(wr, addr);
        end

        wait_idle();
        repeat (3) @(posedge clk_sys);
        #1;
        for (int g = 0; g < 2; g++) begin
            checks++;
            if (sb[g].size() != 0) begin
                errors++;
                $display("FAIL missing_beats[%0d] got %0d pending want 0", g, sb[g].size());
            end
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
